// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port memory between the instruction-fetch requester (I)
// and the memory-access-stage requester (D). Each transaction is granted from
// IDLE, its fields are registered onto mem_*, mem_req is held until mem_ack,
// and a one-cycle ready pulse returns data (or err=1 on timeout).
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed D-over-I priority
//   defined   : when both are eligible, the one not served last wins
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ready  fetch request / completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_rdata/d_ready  data request / completion
//   err                              set together with a ready pulse on timeout
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered request to memory
//   mem_ack/mem_rdata                memory completion and read data
//   stall_f, stall_m                 stall requests for the hazard unit
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255   // 0 disables the timeout
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_f,
  output logic            stall_m
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  logic [1:0]    state;
  logic [CW-1:0] waitCnt;
  logic          iElig;
  logic          dElig;
  logic          grantD;
  logic          grantI;

  // A requester still holding req during its own ready cycle is already done.
  assign iElig = i_req & ~i_ready;
  assign dElig = d_req & ~d_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastServedD;  // 0 = I served last, 1 = D served last

  assign grantD = dElig & (~iElig | ~lastServedD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastServedD <= 1'b0;
    end else if (state == IDLE && (dElig | iElig)) begin
      lastServedD <= grantD;
    end
  end
`else
  assign grantD = dElig;
`endif

  assign grantI  = iElig & ~grantD;
  assign stall_f = i_req & ~i_ready;
  assign stall_m = d_req & ~d_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      // ready and err are single-cycle pulses
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            waitCnt   <= '0;
            state     <= BUSY_D;
          end else if (grantI) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            waitCnt   <= '0;
            state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack in the same cycle as the timeout takes precedence.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_D) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end
          end else if (TIMEOUT_EN && waitCnt == CNT_LIMIT) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
            if (state == BUSY_D) begin
              d_rdata <= '0;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_ready <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (TIMEOUT = 4). Each request pushes its
// expected memory-side request and its expected completion onto queues; a
// negedge monitor that also plays the memory pops and compares them.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_f;
  logic        stall_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  // delay: mem_ack on the delay-th cycle of mem_req (0 = never)
  // len:   expected mem_req high cycles (-1 = do not check)
  // gap:   expected cycles from previous ready to mem_req rise (-1 = do not check)
  typedef struct {
    bit          isD;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          delay;
    int          len;
    int          gap;
  } reqT;

  typedef struct {
    bit          isD;
    logic [31:0] rdata;
    bit          err;
  } respT;

  reqT  expReqQ[$];
  respT expRespQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic reqT mkReq(bit isD, bit we, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] wstrb, logic [31:0] rdata, int delay, int len, int gap);
    reqT r;
    r.isD = isD; r.we = we; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    r.rdata = rdata; r.delay = delay; r.len = len; r.gap = gap;
    return r;
  endfunction

  task automatic pushTx(input bit isD, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] rdata, input int delay, input int gap);
    bit   timedOut;
    respT rs;
    timedOut = (delay == 0) || (delay > TO);
    expReqQ.push_back(mkReq(isD, we, addr, wdata, wstrb, rdata, delay,
                            timedOut ? TO : delay, gap));
    rs.isD = isD;
    rs.rdata = timedOut ? 32'h0 : rdata;
    rs.err = timedOut;
    expRespQ.push_back(rs);
  endtask

  // Memory model + scoreboard monitor, sampled on the falling edge.
  initial begin
    reqT  cur;
    respT rs;
    int   cnt = 0;
    int   cyc = 0;
    int   lastReadyCyc = -100;
    bit   prevReq = 1'b0;
    cur = mkReq(0, 0, 0, 0, 0, 0, 0, -1, -1);
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_req && !prevReq) begin
        if (expReqQ.size() == 0) begin
          check("unexpected-grant", 1, 0);
          cur = mkReq(0, mem_we, mem_addr, mem_wdata, mem_wstrb, 0, 0, -1, -1);
        end else begin
          cur = expReqQ.pop_front();
          check("mem_we", mem_we, cur.we);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
          check("mem_wstrb", mem_wstrb, cur.wstrb);
          if (cur.gap >= 0) check("ready-to-grant-gap", cyc - lastReadyCyc, cur.gap);
        end
        cnt = 1;
      end else if (mem_req) begin
        cnt++;
        check("mem_addr-hold", mem_addr, cur.addr);
      end else if (prevReq) begin
        if (cur.len >= 0) check("mem_req-len", cnt, cur.len);
      end
      prevReq = mem_req;
      mem_ack = mem_req && (cur.delay != 0) && (cnt == cur.delay);
      mem_rdata = mem_ack ? cur.rdata : (32'h5A5A0000 | cnt);

      if (i_ready || d_ready) begin
        lastReadyCyc = cyc;
        if (expRespQ.size() == 0) begin
          check("unexpected-ready", 1, 0);
        end else begin
          rs = expRespQ.pop_front();
          check("ready-port-is-d", d_ready, rs.isD);
          check("both-ready", i_ready & d_ready, 0);
          check("rdata", rs.isD ? d_rdata : i_rdata, rs.rdata);
          check("err", err, rs.err);
          $display("txn %s rdata=%08h err=%0d", rs.isD ? "D" : "I",
                   rs.isD ? d_rdata : i_rdata, err);
        end
      end else if (err) begin
        check("err-without-ready", err, 0);
      end
    end
  end

  // Waits for the requester's ready pulse, checking stall along the way.
  // expCyc counts from the first edge that sees the request (cycle 0).
  task automatic waitReady(input bit isD, input bit holdExtra, input int expCyc);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (isD ? d_ready : i_ready) begin
        seen = 1'b1;
        check(isD ? "stall_m-at-ready" : "stall_f-at-ready", isD ? stall_m : stall_f, 0);
        if (expCyc >= 0) check(isD ? "d_ready-cycle" : "i_ready-cycle", k + 1, expCyc);
      end else begin
        check(isD ? "stall_m-waiting" : "stall_f-waiting", isD ? stall_m : stall_f, 1);
      end
    end
    if (!seen) check(isD ? "d_ready-timeout" : "i_ready-timeout", 0, 1);
    if (holdExtra) begin
      @(negedge clk);
      check("no-regrant-while-held", mem_req, 0);
    end
    if (isD) begin
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    end else begin
      i_req = 1'b0; i_addr = '0;
    end
  endtask

  task automatic driveI(input logic [31:0] addr, input bit holdExtra, input int expCyc);
    i_req = 1'b1;
    i_addr = addr;
    waitReady(1'b0, holdExtra, expCyc);
  endtask

  task automatic driveD(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int expCyc);
    d_req = 1'b1;
    d_we = we;
    d_addr = addr;
    d_wdata = wdata;
    d_wstrb = wstrb;
    waitReady(1'b1, 1'b0, expCyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst-mem_req", mem_req, 0);
    check("rst-mem_addr", mem_addr, 0);
    check("rst-ready", {i_ready, d_ready, err}, 0);
    check("rst-rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, ack on the third mem_req cycle
    pushTx(0, 0, 32'h100, 0, 0, 32'h00500093, 3, -1);
    driveI(32'h100, 1'b0, 4);
    @(negedge clk);

    // Zero-wait store
    pushTx(1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 32'h11112222, 1, -1);
    driveD(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 2);
    @(negedge clk);

    // Simultaneous requests; last served is D at this point
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pushTx(0, 0, 32'h104, 0, 0, 32'h00A00113, 2, -1);
    pushTx(1, 0, 32'h3000, 0, 0, 32'hCAFE0001, 2, 1);
`else
    pushTx(1, 0, 32'h3000, 0, 0, 32'hCAFE0001, 2, -1);
    pushTx(0, 0, 32'h104, 0, 0, 32'h00A00113, 2, 1);
`endif
    fork
      driveD(1'b0, 32'h3000, 0, 0, -1);
      driveI(32'h104, 1'b1, -1);
    join
    @(negedge clk);

    // Timeout: never acked
    pushTx(1, 0, 32'h4000, 0, 0, 32'h77778888, 0, -1);
    driveD(1'b0, 32'h4000, 0, 0, TO + 1);
    @(negedge clk);

    // Ack on the same cycle as the timeout wins
    pushTx(0, 0, 32'h108, 0, 0, 32'h12345678, TO, -1);
    driveI(32'h108, 1'b0, TO + 1);
    @(negedge clk);

    // Reset in the middle of a D transaction
    expReqQ.push_back(mkReq(1, 0, 32'h5000, 0, 0, 0, 0, -1, -1));
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_wdata = '0; d_wstrb = '0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = mem_req;
    end
    check("reset-test-grant", got, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async-reset-mem_req", mem_req, 0);
    check("async-reset-ready", {d_ready, err}, 0);
    pushTx(1, 0, 32'h5000, 0, 0, 32'h0BADF00D, 2, -1);
    @(negedge clk);
    reset = 1'b0;
    check("post-reset-d_ready", d_ready, 0);
    waitReady(1'b1, 1'b0, 3);
    repeat (3) @(negedge clk);

    check("req-queue-drained", expReqQ.size(), 0);
    check("resp-queue-drained", expRespQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
